// File: rtl/wr_queue_ctrl.sv
// wr_queue_ctrl: posted-write queue that retires writes in order through tag lookup, line fetch and data RAM.
// Define WR_QUEUE_STRB_EN to store per-entry byte strobes and to pop all-zero-strobe entries without any access.
module wr_queue_ctrl #(
    parameter int addr_width = 32,
    parameter int data_width = 32,
    parameter int list_depth = 4,
    parameter int list_width = 32,
    parameter int wq_depth = 4,
    localparam int TW = $clog2(list_depth),
    localparam int OW = $clog2(list_width),
    localparam int PW = $clog2(wq_depth),
    localparam int SW = data_width / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_wr_valid,
    output logic                  o_wr_ready,
    input  logic [addr_width-1:0] i_wr_addr,
    input  logic [data_width-1:0] i_wr_data,
    input  logic [SW-1:0]         i_wr_strb,
    output logic [PW:0]           o_wq_count,
    output logic                  o_acc_req,
    output logic [1:0]            o_acc_cmd,
    output logic [addr_width-1:0] o_acc_index,
    output logic [TW-1:0]         o_acc_tag,
    input  logic [2:0]            i_acc_status,
    input  logic [TW-1:0]         i_return_tag,
    input  logic [addr_width-1:0] i_return_index,
    output logic [2:0]            o_proc_status_w,
    output logic [addr_width-1:0] o_proc_addr_w,
    input  logic [2:0]            i_proc_status_r,
    input  logic [addr_width-1:0] i_proc_addr_r,
    output logic                  o_fetch_req,
    input  logic                  i_fetch_gnt,
    input  logic                  i_fetch_done,
    output logic [1:0]            o_fetch_cmd,
    output logic [TW-1:0]         o_fetch_tag,
    output logic [addr_width-1:0] o_fetch_addr,
    output logic [addr_width-1:0] o_fetch_addr_pre,
    output logic                  o_mem_wen,
    input  logic                  i_mem_wready,
    output logic [TW+OW-1:0]      o_mem_waddr,
    output logic [data_width-1:0] o_mem_wdata,
    output logic [SW-1:0]         o_mem_wstrb
);
    localparam logic [2:0] S_IDLE = 3'd0, S_LOOKUP = 3'd1, S_CHECK = 3'd2, S_ALLOC = 3'd3,
                           S_FREQ = 3'd4, S_WAITF = 3'd5, S_WMEM = 3'd6, S_WAITC = 3'd7;
    localparam logic [PW:0] QFULL = (PW+1)'(wq_depth);

    logic [addr_width-1:0] r_q_addr [wq_depth];
    logic [data_width-1:0] r_q_data [wq_depth];
    logic [PW-1:0]         r_wp, r_rp;
    logic [PW:0]           r_count;
    logic [2:0]            r_state;
    logic [TW-1:0]         r_tag;
    logic                  r_dirty;
    logic [1:0]            r_fetch_cmd;
    logic [addr_width-1:0] r_fetch_addr_pre;

    logic [2:0]            w_state_nxt;
    logic [PW:0]           w_count_nxt;
    logic [addr_width-1:0] w_head_addr, w_line;
    logic                  w_skip, w_lookup, w_hit, w_miss, w_alloc, w_freq, w_wmem, w_wmem_hs;
    logic                  w_push, w_pop, w_conflict;

`ifdef WR_QUEUE_STRB_EN
    logic [SW-1:0] r_q_strb [wq_depth];
    assign w_skip      = r_q_strb[r_rp] == '0;
    assign o_mem_wstrb = o_mem_wen ? r_q_strb[r_rp] : '0;
    always_ff @(posedge clk)
        if (w_push) r_q_strb[r_wp] <= i_wr_strb;
`else
    logic w_unused;
    assign w_unused    = ^i_wr_strb;
    assign w_skip      = 1'b0;
    assign o_mem_wstrb = '1;
`endif

    assign w_head_addr = r_q_addr[r_rp];
    // An empty queue reports a zero line address rather than a stale slot.
    assign w_line      = r_count != '0 ? {w_head_addr[addr_width-1:OW], {OW{1'b0}}} : '0;
    assign w_lookup    = r_state == S_LOOKUP;
    assign w_alloc     = r_state == S_ALLOC;
    assign w_freq      = r_state == S_FREQ;
    assign w_wmem      = r_state == S_WMEM;
    assign w_hit       = w_lookup && !w_skip && i_acc_status == 3'b001;
    assign w_miss      = w_lookup && !w_skip && (i_acc_status == 3'b000 || i_acc_status == 3'b100);
    assign w_wmem_hs   = w_wmem && i_mem_wready;
    assign w_conflict  = i_proc_status_r == 3'b010 && i_proc_addr_r == w_line;
    assign o_wr_ready  = r_count != QFULL;
    assign w_push      = i_wr_valid && o_wr_ready;
    assign w_pop       = (w_lookup && w_skip) || (w_hit && i_mem_wready) || w_wmem_hs;
    assign w_count_nxt = r_count + {{PW{1'b0}}, w_push} - {{PW{1'b0}}, w_pop};

    assign o_wq_count       = r_count;
    assign o_acc_req        = (w_lookup && !w_skip) || w_alloc || w_wmem_hs;
    assign o_acc_cmd        = w_alloc ? 2'b10 : w_wmem_hs ? 2'b11 : 2'b00;
    assign o_acc_index      = o_acc_req ? w_line : '0;
    assign o_acc_tag        = w_wmem_hs ? r_tag : '0;
    assign o_proc_status_w  = r_state == S_CHECK ? 3'b001 : w_wmem_hs ? 3'b011 :
                              (w_alloc || w_freq || r_state == S_WAITF || w_wmem) ? 3'b010 : 3'b000;
    assign o_proc_addr_w    = w_line;
    assign o_fetch_req      = w_freq;
    assign o_fetch_cmd      = r_fetch_cmd;
    assign o_fetch_tag      = w_freq ? r_tag : '0;
    assign o_fetch_addr     = w_line;
    assign o_fetch_addr_pre = r_fetch_addr_pre;
    assign o_mem_wen        = w_hit || w_wmem;
    assign o_mem_waddr      = o_mem_wen ? {w_hit ? i_return_tag : r_tag, w_head_addr[OW-1:0]} : '0;
    assign o_mem_wdata      = o_mem_wen ? r_q_data[r_rp] : '0;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   w_state_nxt = r_count != '0 ? S_LOOKUP : S_IDLE;
            S_LOOKUP: w_state_nxt = w_pop ? (w_count_nxt != '0 ? S_LOOKUP : S_IDLE) : w_miss ? S_CHECK : S_LOOKUP;
            S_CHECK:  w_state_nxt = w_conflict ? S_WAITC : S_ALLOC;
            S_ALLOC:  w_state_nxt = S_FREQ;
            S_FREQ:   w_state_nxt = i_fetch_gnt ? S_WAITF : S_FREQ;
            S_WAITF:  w_state_nxt = i_fetch_done ? S_WMEM : S_WAITF;
            S_WMEM:   w_state_nxt = w_wmem_hs ? (w_count_nxt != '0 ? S_LOOKUP : S_IDLE) : S_WMEM;
            S_WAITC:  w_state_nxt = i_proc_status_r == 3'b011 ? S_LOOKUP : S_WAITC;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk)
        if (w_push) begin
            r_q_addr[r_wp] <= i_wr_addr;
            r_q_data[r_wp] <= i_wr_data;
        end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_state          <= S_IDLE;
            r_wp             <= '0;
            r_rp             <= '0;
            r_count          <= '0;
            r_tag            <= '0;
            r_dirty          <= 1'b0;
            r_fetch_cmd      <= 2'b00;
            r_fetch_addr_pre <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            if (w_push) r_wp <= r_wp + PW'(1);
            if (w_pop) r_rp <= r_rp + PW'(1);
            // Miss kind comes from the lookup; the allocate response may report something else.
            if (w_miss) r_dirty <= i_acc_status == 3'b100;
            if (w_alloc) begin
                r_tag            <= i_return_tag;
                r_fetch_addr_pre <= i_return_index;
                r_fetch_cmd      <= r_dirty ? 2'b10 : 2'b01;
            end
        end
endmodule

// File: tb/tb_wr_queue_ctrl.sv
// tb_wr_queue_ctrl: directed stimulus with a queue-level reference model checked every cycle.
module tb_wr_queue_ctrl;
    localparam int AW = 32, DW = 32, SW = 4, TW = 2, OW = 5, QD = 4;

    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    logic          i_wr_valid = 0, i_fetch_gnt = 0, i_fetch_done = 0, i_mem_wready = 0;
    logic [AW-1:0] i_wr_addr = 0, i_return_index = 0, i_proc_addr_r = 0;
    logic [DW-1:0] i_wr_data = 0;
    logic [SW-1:0] i_wr_strb = 4'hF;
    logic [2:0]    i_acc_status = 0, i_proc_status_r = 0;
    logic [TW-1:0] i_return_tag = 0;

    logic          o_wr_ready, o_acc_req, o_fetch_req, o_mem_wen;
    logic [2:0]    o_wq_count, o_proc_status_w;
    logic [1:0]    o_acc_cmd, o_fetch_cmd;
    logic [AW-1:0] o_acc_index, o_proc_addr_w, o_fetch_addr, o_fetch_addr_pre;
    logic [TW-1:0] o_acc_tag, o_fetch_tag;
    logic [TW+OW-1:0] o_mem_waddr;
    logic [DW-1:0] o_mem_wdata;
    logic [SW-1:0] o_mem_wstrb;

    wr_queue_ctrl dut (
        .clk(clk), .rst(rst), .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready),
        .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data), .i_wr_strb(i_wr_strb), .o_wq_count(o_wq_count),
        .o_acc_req(o_acc_req), .o_acc_cmd(o_acc_cmd), .o_acc_index(o_acc_index), .o_acc_tag(o_acc_tag),
        .i_acc_status(i_acc_status), .i_return_tag(i_return_tag), .i_return_index(i_return_index),
        .o_proc_status_w(o_proc_status_w), .o_proc_addr_w(o_proc_addr_w),
        .i_proc_status_r(i_proc_status_r), .i_proc_addr_r(i_proc_addr_r),
        .o_fetch_req(o_fetch_req), .i_fetch_gnt(i_fetch_gnt), .i_fetch_done(i_fetch_done),
        .o_fetch_cmd(o_fetch_cmd), .o_fetch_tag(o_fetch_tag), .o_fetch_addr(o_fetch_addr),
        .o_fetch_addr_pre(o_fetch_addr_pre), .o_mem_wen(o_mem_wen), .i_mem_wready(i_mem_wready),
        .o_mem_waddr(o_mem_waddr), .o_mem_wdata(o_mem_wdata), .o_mem_wstrb(o_mem_wstrb)
    );

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AW-1:0] line_of(input logic [AW-1:0] a);
        return {a[AW-1:OW], {OW{1'b0}}};
    endfunction

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [SW-1:0] s;
    } ent_t;

    ent_t q[$];
    bit model_en = 1;

    // Reference: an in-order queue; a RAM write handshake retires the head.
    initial begin
        logic p_wen_hold, p_freq_hold, full;
        logic [TW+OW-1:0] p_waddr;
        logic [DW-1:0] p_wdata;
        logic [TW-1:0] p_ftag;
        p_wen_hold = 0;
        p_freq_hold = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                q.delete();
                p_wen_hold = 0;
                p_freq_hold = 0;
            end else if (model_en) begin
                chk("m_count", o_wq_count, q.size());
                chk("m_ready", o_wr_ready, q.size() < QD);
                if (q.size() == 0) begin
                    chk("m_empty_wen", o_mem_wen, 0);
                    chk("m_empty_acc", o_acc_req, 0);
                end else begin
                    chk("m_proc_addr", o_proc_addr_w, line_of(q[0].a));
                    if (o_mem_wen) begin
                        chk("m_wdata", o_mem_wdata, q[0].d);
                        chk("m_woff", o_mem_waddr[OW-1:0], q[0].a[OW-1:0]);
`ifdef WR_QUEUE_STRB_EN
                        chk("m_wstrb", o_mem_wstrb, q[0].s);
`else
                        chk("m_wstrb", o_mem_wstrb, 4'hF);
`endif
                    end
                    if (o_acc_req) chk("m_acc_index", o_acc_index, line_of(q[0].a));
                end
                if (!o_acc_req) chk("m_acc_idle", {o_acc_cmd, o_acc_index, o_acc_tag}, 0);
                if (p_wen_hold) begin
                    chk("m_wen_hold", o_mem_wen, 1);
                    chk("m_waddr_hold", o_mem_waddr, p_waddr);
                    chk("m_wdata_hold", o_mem_wdata, p_wdata);
                end
                if (p_freq_hold) begin
                    chk("m_freq_hold", o_fetch_req, 1);
                    chk("m_ftag_hold", o_fetch_tag, p_ftag);
                end
                p_wen_hold = o_mem_wen && !i_mem_wready;
                p_waddr = o_mem_waddr;
                p_wdata = o_mem_wdata;
                p_freq_hold = o_fetch_req && !i_fetch_gnt;
                p_ftag = o_fetch_tag;
                full = q.size() == QD;
                if (o_mem_wen && i_mem_wready && q.size() != 0) void'(q.pop_front());
                if (i_wr_valid && !full) q.push_back('{i_wr_addr, i_wr_data, i_wr_strb});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        logic [7:0] pat;
        logic [4:0] rdy;
        logic [DW-1:0] got [4];
        int n, cnt;
        repeat (2) cyc();
        chk("rst_count", o_wq_count, 0);
        chk("rst_ready", o_wr_ready, 1);
        chk("rst_outs", {o_mem_wen, o_acc_req, o_fetch_req, o_proc_status_w, o_fetch_cmd}, 0);
        chk("rst_addrs", {o_fetch_addr_pre, o_proc_addr_w, o_fetch_addr}, 0);
        rst = 0;

        // hit stream: four back-to-back writes to 0x100
        i_acc_status = 3'b001; i_return_tag = 2; i_mem_wready = 1;
        pat = 0;
        for (int i = 0; i < 8; i++) begin
            i_wr_valid = i < 4; i_wr_addr = 32'h100; i_wr_data = 32'hA0 + i;
            #1;
            pat[i] = o_mem_wen;
            if (i == 2) begin
                chk("hit_waddr", o_mem_waddr, 7'h40);
                chk("hit_wdata", o_mem_wdata, 32'hA0);
            end
            cyc();
        end
        chk("hit_pattern", pat, 8'h3C);
        chk("hit_drained", o_wq_count, 0);

        // full queue: fifth write refused while RAM stalls, then in-order drain
        i_mem_wready = 0;
        for (int i = 0; i < 5; i++) begin
            i_wr_valid = 1; i_wr_addr = 32'h180 + i; i_wr_data = 32'hB0 + i;
            #1;
            rdy[i] = o_wr_ready;
            cyc();
        end
        chk("full_ready_seq", rdy, 5'b01111);
        chk("full_count", o_wq_count, 4);
        chk("full_ready", o_wr_ready, 0);
        i_wr_valid = 0; i_mem_wready = 1;
        n = 0;
        for (int k = 0; k < 12 && n < 4; k++) begin
            #1;
            if (o_mem_wen) begin
                got[n] = o_mem_wdata;
                n++;
            end
            cyc();
        end
        chk("full_drain_n", n, 4);
        for (int j = 0; j < 4; j++) chk("full_order", got[j], 32'hB0 + j);
        chk("full_empty", o_wq_count, 0);

        // dirty miss
        i_acc_status = 3'b100; i_return_tag = 1; i_return_index = 32'h400;
        i_wr_valid = 1; i_wr_addr = 32'h203; i_wr_data = 32'hC0;
        cyc();
        i_wr_valid = 0;
        for (int k = 0; k < 10 && !o_fetch_req; k++) cyc();
        chk("dm_freq", o_fetch_req, 1);
        chk("dm_fcmd", o_fetch_cmd, 2'b10);
        chk("dm_fpre", o_fetch_addr_pre, 32'h400);
        chk("dm_ftag", o_fetch_tag, 1);
        chk("dm_faddr", o_fetch_addr, 32'h200);
        chk("dm_pstat_fr", o_proc_status_w, 3'b010);
        cyc();
        chk("dm_freq_held", o_fetch_req, 1);
        i_fetch_gnt = 1; cyc(); i_fetch_gnt = 0;
        #1;
        chk("dm_waitf", {o_fetch_req, o_mem_wen, o_proc_status_w}, 5'b00010);
        i_fetch_done = 1; cyc(); i_fetch_done = 0;
        #1;
        chk("dm_wen", o_mem_wen, 1);
        chk("dm_acc", {o_acc_req, o_acc_cmd, o_acc_tag}, 5'b1_11_01);
        chk("dm_pstat", o_proc_status_w, 3'b011);
        chk("dm_waddr", o_mem_waddr, 7'h23);
        cyc();
        chk("dm_done", {o_wq_count, o_proc_status_w}, 0);

        // conflict with the read controller
        i_acc_status = 3'b000; i_proc_status_r = 3'b010; i_proc_addr_r = 32'h300;
        i_wr_valid = 1; i_wr_addr = 32'h304; i_wr_data = 32'hD0;
        cyc();
        i_wr_valid = 0;
        for (int k = 0; k < 10 && o_proc_status_w != 3'b001; k++) cyc();
        chk("cf_check", o_proc_status_w, 3'b001);
        cyc();
        chk("cf_wait", {o_proc_status_w, o_fetch_req, o_acc_req}, 0);
        cnt = 0;
        repeat (3) begin
            cyc();
            cnt += int'(o_fetch_req) + int'(o_acc_req);
        end
        chk("cf_no_req", cnt, 0);
        i_proc_status_r = 3'b011; i_acc_status = 3'b001;
        cyc();
        chk("cf_relookup", {o_acc_req, o_acc_cmd, o_mem_wen}, 4'b1001);
        chk("cf_wdata", o_mem_wdata, 32'hD0);
        i_proc_status_r = 0;
        cyc();
        chk("cf_done", o_wq_count, 0);

        // reset during WAIT_FETCH with three entries queued
        i_acc_status = 3'b000; i_mem_wready = 0;
        for (int i = 0; i < 3; i++) begin
            i_wr_valid = 1; i_wr_addr = 32'h500 + 32'h20 * i; i_wr_data = 32'hE0 + i;
            cyc();
        end
        i_wr_valid = 0;
        for (int k = 0; k < 10 && !o_fetch_req; k++) cyc();
        chk("rs_fcmd", o_fetch_cmd, 2'b01);
        i_fetch_gnt = 1; cyc(); i_fetch_gnt = 0;
        #1;
        chk("rs_pre_count", o_wq_count, 3);
        rst = 1;
        #1;
        chk("rs_count", o_wq_count, 0);
        chk("rs_outs", {o_fetch_req, o_mem_wen, o_proc_status_w}, 0);
        chk("rs_ready", o_wr_ready, 1);
        cyc();
        rst = 0;
        cyc();

        i_acc_status = 3'b001; i_mem_wready = 1;
`ifdef WR_QUEUE_STRB_EN
        i_wr_valid = 1; i_wr_addr = 32'h100; i_wr_data = 32'hF0; i_wr_strb = 4'b0101;
        cyc();
        i_wr_valid = 0;
        for (int k = 0; k < 10 && !o_mem_wen; k++) cyc();
        chk("st_wstrb", o_mem_wstrb, 4'b0101);
        repeat (2) cyc();
        model_en = 0;
        i_wr_valid = 1; i_wr_data = 32'hF1; i_wr_strb = 4'b0000;
        cyc();
        i_wr_valid = 0;
        cnt = 0;
        repeat (5) begin
            cnt += int'(o_acc_req) + int'(o_mem_wen);
            cyc();
        end
        chk("st_zero_noacc", cnt, 0);
        chk("st_zero_popped", o_wq_count, 0);
`else
        i_wr_valid = 1; i_wr_addr = 32'h100; i_wr_data = 32'hF0; i_wr_strb = 4'b0000;
        cyc();
        i_wr_valid = 0;
        for (int k = 0; k < 10 && !o_mem_wen; k++) cyc();
        chk("st_wen", o_mem_wen, 1);
        chk("st_wstrb_ones", o_mem_wstrb, 4'hF);
        repeat (2) cyc();
        chk("st_done", o_wq_count, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
